glyph_plotter: RTL and testbench

Renders one 8x8 text glyph per request into the 320x240 frame buffer. It sits between html_parser (which decides what character goes in which text cell) and vga_adapter (which accepts single-pixel writes). It fetches glyph rows from an external synchronous font ROM and emits one pixel write per cycle on the adapter's x/y/colour/plot port.

---
 rtl/glyph_plotter.sv | 135 +++++++++++++
 tb/tb_glyph_plotter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_plotter.sv
// Renders one 8x8 glyph per request as a stream of single-pixel writes, fetching
// each glyph row from a one-cycle-latency font ROM. Optional macro: TRANSPARENT_BG_EN.
module glyph_plotter #(
    parameter int unsigned CELL_COLS = 40,
    parameter int unsigned CELL_ROWS = 30
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [7:0]  char_code,
    input  logic [5:0]  cell_col,
    input  logic [4:0]  cell_row,
    input  logic [2:0]  fg_colour,
    input  logic [2:0]  bg_colour,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAW} state_t;

    state_t      state_q;
    logic [7:0]  char_q;
    logic [5:0]  col_q;
    logic [4:0]  row_q;
    logic [2:0]  fg_q;
    logic [2:0]  bg_q;
    logic [2:0]  glyph_row_q;
    logic [2:0]  pix_q;
    logic [7:0]  shift_q;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [2:0]  colour_q;
    logic        plot_q;
    logic        done_q;
    logic        ready_q;
    logic        out_of_range_c;

    assign out_of_range_c = (32'(cell_col) >= CELL_COLS) || (32'(cell_row) >= CELL_ROWS);

    // Clear glyph bits are skipped when the background is left untouched.
    function automatic logic pix_plot(input logic glyph_bit);
`ifdef TRANSPARENT_BG_EN
        return glyph_bit;
`else
        return 1'b1 | glyph_bit;
`endif
    endfunction

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            char_q      <= 8'd0;
            col_q       <= 6'd0;
            row_q       <= 5'd0;
            fg_q        <= 3'd0;
            bg_q        <= 3'd0;
            glyph_row_q <= 3'd0;
            pix_q       <= 3'd0;
            shift_q     <= 8'd0;
            x_q         <= 9'd0;
            y_q         <= 8'd0;
            colour_q    <= 3'd0;
            plot_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (char_valid) begin
                        char_q <= char_code;
                        col_q  <= cell_col;
                        row_q  <= cell_row;
                        fg_q   <= fg_colour;
                        bg_q   <= bg_colour;
                        if (out_of_range_c) begin
                            done_q <= 1'b1;
                        end else begin
                            glyph_row_q <= 3'd0;
                            ready_q     <= 1'b0;
                            state_q     <= FETCH;
                        end
                    end
                end
                FETCH: state_q <= WAIT;
                // Outputs are registered, so pixel 0 is loaded straight from the ROM
                // and the shift register keeps only the remaining seven bits.
                WAIT: begin
                    shift_q  <= {font_data[6:0], 1'b0};
                    pix_q    <= 3'd0;
                    x_q      <= {col_q, 3'd0};
                    y_q      <= {row_q, glyph_row_q};
                    colour_q <= font_data[7] ? fg_q : bg_q;
                    plot_q   <= pix_plot(font_data[7]);
                    state_q  <= DRAW;
                end
                DRAW: begin
                    if (pix_q == 3'd7) begin
                        plot_q <= 1'b0;
                        if (glyph_row_q != 3'd7) begin
                            glyph_row_q <= glyph_row_q + 3'd1;
                            state_q     <= FETCH;
                        end else begin
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        pix_q    <= pix_q + 3'd1;
                        x_q      <= {col_q, pix_q + 3'd1};
                        colour_q <= shift_q[7] ? fg_q : bg_q;
                        plot_q   <= pix_plot(shift_q[7]);
                        shift_q  <= {shift_q[6:0], 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign char_ready = ready_q;
    assign font_addr  = {char_q, glyph_row_q};
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign done       = done_q;

endmodule

// File: tb/tb_glyph_plotter.sv
// Directed bench for glyph_plotter: bench-side font ROM, cycle-exact pixel stream
// checks, out-of-range drops, held requests and mid-glyph reset.
module tb_glyph_plotter;

`ifdef TRANSPARENT_BG_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_code;
    logic [5:0]  cell_col;
    logic [4:0]  cell_row;
    logic [2:0]  fg_colour;
    logic [2:0]  bg_colour;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        done;

    int n_checks;
    int n_pass;

    glyph_plotter dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .char_code (char_code),
        .cell_col  (cell_col),
        .cell_row  (cell_row),
        .fg_colour (fg_colour),
        .bg_colour (bg_colour),
        .font_addr (font_addr),
        .font_data (font_data),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] font_row(input logic [7:0] ch, input logic [2:0] r);
        logic [7:0] rows [8];
        case (ch)
            8'h41: rows = '{8'h18, 8'h3C, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};
            8'h5A: rows = '{8'hFF, 8'h06, 8'h0C, 8'hA5, 8'h30, 8'h60, 8'hFF, 8'h81};
            default: for (int i = 0; i < 8; i++) rows[i] = ch ^ 8'(i * 37);
        endcase
        return rows[r];
    endfunction

    // Synchronous ROM: address registered, output decoded from the registered address.
    logic [10:0] rom_addr_q;
    always @(posedge clk) rom_addr_q <= font_addr;
    assign font_data = font_row(rom_addr_q[10:3], rom_addr_q[2:0]);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Checks cycles 1..stop after an accept edge; entered #1 after that edge.
    task automatic glyph_check(input logic [7:0] ch, input logic [5:0] col, input logic [4:0] row,
                               input logic [2:0] fg, input logic [2:0] bg, input int stop);
        int r, p;
        logic [7:0] bits;
        logic gbit, eplot;
        logic [2:0] ecol;
        for (int k = 1; k <= stop; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (k == 81) begin
                check_eq("end", {29'd0, done, char_ready, plot}, 32'b110);
            end else begin
                r = (k - 1) / 10;
                p = (k - 1) % 10 - 2;
                if (p == -2) begin
                    check_eq($sformatf("fetch c%0d", k), 32'(font_addr), 32'({ch, 3'(r)}));
                    check_eq($sformatf("ctl c%0d", k), {29'd0, done, char_ready, plot}, 32'b000);
                end else if (p == -1) begin
                    check_eq($sformatf("ctl c%0d", k), {29'd0, done, char_ready, plot}, 32'b000);
                end else begin
                    bits  = font_row(ch, 3'(r));
                    gbit  = bits[7 - p];
                    eplot = gbit | !TRANSP;
                    ecol  = gbit ? fg : bg;
                    if (eplot)
                        check_eq($sformatf("pix c%0d", k),
                                 32'({done, char_ready, plot, x, y, colour}),
                                 32'({1'b0, 1'b0, 1'b1, 9'(int'(col) * 8 + p), 8'(int'(row) * 8 + r), ecol}));
                    else
                        check_eq($sformatf("skip c%0d", k), {29'd0, done, char_ready, plot}, 32'b000);
                end
            end
        end
    endtask

    // Presents a request #1 after an edge; returns #1 after the accept edge.
    task automatic request(input logic [7:0] ch, input logic [5:0] col, input logic [4:0] row,
                           input logic [2:0] fg, input logic [2:0] bg);
        char_code  = ch;
        cell_col   = col;
        cell_row   = row;
        fg_colour  = fg;
        bg_colour  = bg;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        char_valid = 1'b0;
        char_code  = 8'd0;
        cell_col   = 6'd0;
        cell_row   = 5'd0;
        fg_colour  = 3'd0;
        bg_colour  = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst ctl", {29'd0, done, char_ready, plot}, 32'b010);
        check_eq("rst pix", 32'({x, y, colour}), 32'd0);
        check_eq("rst addr", 32'(font_addr), 32'd0);

        // Glyph 'A' at the origin.
        request(8'h41, 6'd0, 5'd0, 3'b000, 3'b111);
        char_valid = 1'b0;
        glyph_check(8'h41, 6'd0, 5'd0, 3'b000, 3'b111, 81);
        @(posedge clk);
        #1;
        check_eq("idle after", {29'd0, done, char_ready, plot}, 32'b010);
        check_eq("hold pix", 32'({x, y, colour}), 32'({9'd7, 8'd7, 3'b111}));

        // Bottom-right cell, includes the 8'hA5 row.
        request(8'h5A, 6'd39, 5'd29, 3'b101, 3'b010);
        char_valid = 1'b0;
        glyph_check(8'h5A, 6'd39, 5'd29, 3'b101, 3'b010, 81);

        // Out-of-range drops, back to back.
        request(8'h42, 6'd40, 5'd0, 3'b001, 3'b000);
        check_eq("drop col", {29'd0, done, char_ready, plot}, 32'b110);
        cell_col = 6'd0;
        cell_row = 5'd30;
        @(posedge clk);
        #1;
        check_eq("drop row", {29'd0, done, char_ready, plot}, 32'b110);
        cell_col = 6'd63;
        cell_row = 5'd31;
        @(posedge clk);
        #1;
        check_eq("drop both", {29'd0, done, char_ready, plot}, 32'b110);
        char_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("drop end", {29'd0, done, char_ready, plot}, 32'b010);

        // Request held high across three glyphs.
        request(8'h41, 6'd1, 5'd2, 3'b011, 3'b100);
        char_code = 8'h5A;
        cell_col  = 6'd10;
        cell_row  = 5'd5;
        glyph_check(8'h41, 6'd1, 5'd2, 3'b011, 3'b100, 81);
        @(posedge clk);
        #1;
        char_code = 8'h33;
        cell_col  = 6'd20;
        cell_row  = 5'd15;
        glyph_check(8'h5A, 6'd10, 5'd5, 3'b011, 3'b100, 81);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        glyph_check(8'h33, 6'd20, 5'd15, 3'b011, 3'b100, 81);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("no dup", {29'd0, done, char_ready, plot}, 32'b010);
        end

        // Reset during cycle 40 abandons the glyph.
        request(8'h41, 6'd3, 5'd4, 3'b110, 3'b001);
        char_valid = 1'b0;
        glyph_check(8'h41, 6'd3, 5'd4, 3'b110, 3'b001, 39);
        @(posedge clk);
        #1;
        check_eq("pre rst", 32'(plot), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid rst", {29'd0, done, char_ready, plot}, 32'b010);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("post rst", {29'd0, done, char_ready, plot}, 32'b010);
        end
        request(8'h77, 6'd12, 5'd7, 3'b010, 3'b101);
        char_valid = 1'b0;
        glyph_check(8'h77, 6'd12, 5'd7, 3'b010, 3'b101, 81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
